// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands are loaded in parallel, one full-add/subtract cell
// consumes them LSB-first, and the result is presented in parallel with a one-cycle done pulse.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic             mode_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;

  logic             bit_s;
  logic             c_d;
  logic [WIDTH:0]   res_wide_s;
  logic [WIDTH-1:0] res_sh_d;
  logic             last_s;

  // One-bit full-adder / full-subtractor cell and the next result-shift value
  always_comb begin
    bit_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    if (mode_q) begin
      c_d = (~a_sh_q[0] & b_sh_q[0]) | (c_q & ~(a_sh_q[0] ^ b_sh_q[0]));
    end else begin
      c_d = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    end
    // Widened concatenation keeps the MSB-side insert legal for WIDTH=1
    res_wide_s = {bit_s, res_sh_q};
    res_sh_d   = res_wide_s[WIDTH:1];
    last_s     = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            mode_q  <= mode;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1'b1;
          b_sh_q   <= b_sh_q >> 1'b1;
          res_sh_q <= res_sh_d;
          c_q      <= c_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_s) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_sh_d;
            cout_q   <= c_d;
            state_q  <= S_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule
